// File: rtl/par_to_ser_tx.sv
// rtl/par_to_ser_tx.sv - framed parallel-to-serial transmitter with holding FIFO
module par_to_ser_tx #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 2,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] P_IN,
    input  logic             P_LOAD,
    output logic             P_READY,
    output logic             S_OUT,
    output logic             S_START,
    output logic             S_BUSY,
    output logic             TX_DONE
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             s_out_q, s_out_d;
    logic             s_start_q, s_start_d;
    logic             s_busy_q, s_busy_d;
    logic             tx_done_q, tx_done_d;
    logic             push, pop, start, fifo_empty;
    logic [WIDTH-1:0] head;

    assign P_READY    = (count_q != FULL);
    assign fifo_empty = (count_q == '0);
    assign push       = P_LOAD && P_READY;
    assign head       = mem_q[rd_ptr_q];

    assign S_OUT   = s_out_q;
    assign S_START = s_start_q;
    assign S_BUSY  = s_busy_q;
    assign TX_DONE = tx_done_q;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= P_IN;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            // simultaneous push and pop leaves the count unchanged
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sreg_d    = sreg_q;
        s_out_d   = 1'b0;
        s_start_d = 1'b0;
        s_busy_d  = 1'b0;
        tx_done_d = 1'b0;
        start     = 1'b0;
        pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start = !fifo_empty;
            end
            ST_SHIFT: begin
                if (bit_cnt_q != BIT_LAST) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    s_busy_d  = 1'b1;
                    if (MSB_FIRST != 0) begin
                        s_out_d = sreg_q[WIDTH-1];
                        sreg_d  = {sreg_q[WIDTH-2:0], 1'b0};
                    end else begin
                        s_out_d = sreg_q[0];
                        sreg_d  = {1'b0, sreg_q[WIDTH-1:1]};
                    end
                end else begin
                    tx_done_d = 1'b1;
                    if (GAP > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                        s_busy_d  = 1'b1;
                    end else if (!fifo_empty) begin
                        start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q != GAP_LAST) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                    s_busy_d  = 1'b1;
                end else if (!fifo_empty) begin
                    start = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // frame start: the first bit leaves on the same edge as the pop
        if (start) begin
            pop       = 1'b1;
            state_d   = ST_SHIFT;
            bit_cnt_d = '0;
            s_start_d = 1'b1;
            s_busy_d  = 1'b1;
            if (MSB_FIRST != 0) begin
                s_out_d = head[WIDTH-1];
                sreg_d  = {head[WIDTH-2:0], 1'b0};
            end else begin
                s_out_d = head[0];
                sreg_d  = {1'b0, head[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sreg_q    <= '0;
            s_out_q   <= 1'b0;
            s_start_q <= 1'b0;
            s_busy_q  <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sreg_q    <= sreg_d;
            s_out_q   <= s_out_d;
            s_start_q <= s_start_d;
            s_busy_q  <= s_busy_d;
            tx_done_q <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_par_to_ser_tx.sv
// tb/tb_par_to_ser_tx.sv - directed bench for par_to_ser_tx across four configurations
module tb_par_to_ser_tx;

    logic        CLK;
    logic        RESET;
    logic [31:0] P_IN;
    logic        P_LOAD;
    logic [3:0]  rdy, so, ss, sb, td;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rx_q[$];
    logic [31:0] rx_sh;
    int          rx_cnt;

    par_to_ser_tx #(.WIDTH(32), .DEPTH(2), .MSB_FIRST(1), .GAP(1)) u0 (
        .CLK(CLK), .RESET(RESET), .P_IN(P_IN), .P_LOAD(P_LOAD), .P_READY(rdy[0]),
        .S_OUT(so[0]), .S_START(ss[0]), .S_BUSY(sb[0]), .TX_DONE(td[0]));
    par_to_ser_tx #(.WIDTH(32), .DEPTH(2), .MSB_FIRST(0), .GAP(1)) u1 (
        .CLK(CLK), .RESET(RESET), .P_IN(P_IN), .P_LOAD(P_LOAD), .P_READY(rdy[1]),
        .S_OUT(so[1]), .S_START(ss[1]), .S_BUSY(sb[1]), .TX_DONE(td[1]));
    par_to_ser_tx #(.WIDTH(32), .DEPTH(2), .MSB_FIRST(1), .GAP(0)) u2 (
        .CLK(CLK), .RESET(RESET), .P_IN(P_IN), .P_LOAD(P_LOAD), .P_READY(rdy[2]),
        .S_OUT(so[2]), .S_START(ss[2]), .S_BUSY(sb[2]), .TX_DONE(td[2]));
    par_to_ser_tx #(.WIDTH(32), .DEPTH(2), .MSB_FIRST(1), .GAP(3)) u3 (
        .CLK(CLK), .RESET(RESET), .P_IN(P_IN), .P_LOAD(P_LOAD), .P_READY(rdy[3]),
        .S_OUT(so[3]), .S_START(ss[3]), .S_BUSY(sb[3]), .TX_DONE(td[3]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // stand-in for the serial-to-parallel receiver, listening to u0
    always @(negedge CLK) begin
        if (!RESET) begin
            rx_cnt = 0;
        end else if (ss[0]) begin
            rx_sh  = {31'b0, so[0]};
            rx_cnt = 1;
        end else if (rx_cnt > 0 && rx_cnt < 32) begin
            rx_sh  = {rx_sh[30:0], so[0]};
            rx_cnt = rx_cnt + 1;
        end
        if (rx_cnt == 32) begin
            rx_q.push_back(rx_sh);
            rx_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        P_LOAD = 1'b0;
        P_IN   = '0;
        RESET  = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        tick();
        rx_q.delete();
    endtask

    task automatic load(input logic [31:0] w);
        P_IN   = w;
        P_LOAD = 1'b1;
        tick();
        P_LOAD = 1'b0;
        P_IN   = 32'hDEAD_0000;
    endtask

    task automatic test_reset();
        P_LOAD = 1'b0;
        P_IN   = '0;
        RESET  = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({so, ss, sb, td} !== 16'h0) $display("FAIL reset_outputs got=%h exp=0000", {so, ss, sb, td});
        else n_pass++;
        n_checks++;
        if (rdy !== 4'hF) $display("FAIL reset_ready got=%b exp=1111", rdy);
        else n_pass++;
        RESET = 1'b1;
        tick();
        n_checks++;
        if ({so, ss, sb, td} !== 16'h0) $display("FAIL reset_release_idle got=%h exp=0000", {so, ss, sb, td});
        else n_pass++;
    endtask

    task automatic test_single();
        logic [3:0] exp;
        do_reset();
        load(32'h0000FFFF);
        n_checks++;
        if ({so[0], ss[0]} !== 2'b00) $display("FAIL single_latency got=%b exp=00", {so[0], ss[0]});
        else n_pass++;
        for (int c = 1; c <= 35; c++) begin
            tick();
            if (c <= 32)       exp = {(c > 16) ? 1'b1 : 1'b0, (c == 1) ? 1'b1 : 1'b0, 1'b1, 1'b0};
            else if (c == 33)  exp = 4'b0011;
            else               exp = 4'b0000;
            n_checks++;
            if ({so[0], ss[0], sb[0], td[0]} !== exp)
                $display("FAIL single_msb c=%0d got=%b exp=%b", c, {so[0], ss[0], sb[0], td[0]}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] exp;
        do_reset();
        load(32'h0000FFFF);
        for (int c = 1; c <= 33; c++) begin
            tick();
            if (c <= 32) exp = {(c <= 16) ? 1'b1 : 1'b0, (c == 1) ? 1'b1 : 1'b0, 1'b1, 1'b0};
            else         exp = 4'b0011;
            n_checks++;
            if ({so[1], ss[1], sb[1], td[1]} !== exp)
                $display("FAIL lsb_ffff c=%0d got=%b exp=%b", c, {so[1], ss[1], sb[1], td[1]}, exp);
            else n_pass++;
        end
        load(32'h80000001);
        for (int c = 1; c <= 33; c++) begin
            tick();
            if (c <= 32) exp = {(c == 1 || c == 32) ? 1'b1 : 1'b0, (c == 1) ? 1'b1 : 1'b0, 1'b1, 1'b0};
            else         exp = 4'b0011;
            n_checks++;
            if ({so[1], ss[1], sb[1], td[1]} !== exp)
                $display("FAIL lsb_8001 c=%0d got=%b exp=%b", c, {so[1], ss[1], sb[1], td[1]}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wa, wb;
        logic [3:0]  e2, e3;
        wa = 32'hA5A5A5A5;
        wb = 32'h5A5A5A5A;
        do_reset();
        P_LOAD = 1'b1;
        P_IN   = wa;
        tick();
        P_IN = wb;
        tick();
        P_LOAD = 1'b0;
        P_IN   = 32'hFFFFFFFF;
        for (int c = 1; c <= 72; c++) begin
            if (c > 1) tick();
            if (c <= 32)      e2 = {wa[32 - c], (c == 1) ? 1'b1 : 1'b0, 1'b1, 1'b0};
            else if (c <= 64) e2 = {wb[64 - c], (c == 33) ? 1'b1 : 1'b0, 1'b1, (c == 33) ? 1'b1 : 1'b0};
            else if (c == 65) e2 = 4'b0001;
            else              e2 = 4'b0000;
            if (c <= 32)      e3 = {wa[32 - c], (c == 1) ? 1'b1 : 1'b0, 1'b1, 1'b0};
            else if (c <= 35) e3 = {1'b0, 1'b0, 1'b1, (c == 33) ? 1'b1 : 1'b0};
            else if (c <= 67) e3 = {wb[67 - c], (c == 36) ? 1'b1 : 1'b0, 1'b1, 1'b0};
            else if (c == 68) e3 = 4'b0011;
            else if (c <= 70) e3 = 4'b0010;
            else              e3 = 4'b0000;
            n_checks++;
            if ({so[2], ss[2], sb[2], td[2]} !== e2)
                $display("FAIL b2b_gap0 c=%0d got=%b exp=%b", c, {so[2], ss[2], sb[2], td[2]}, e2);
            else n_pass++;
            n_checks++;
            if ({so[3], ss[3], sb[3], td[3]} !== e3)
                $display("FAIL b2b_gap3 c=%0d got=%b exp=%b", c, {so[3], ss[3], sb[3], td[3]}, e3);
            else n_pass++;
        end
    endtask

    task automatic test_full_fifo();
        logic [31:0] w [4];
        w[0] = 32'h11111111;
        w[1] = 32'h22222222;
        w[2] = 32'h33333333;
        w[3] = 32'h44444444;
        do_reset();
        load(w[0]);
        tick();
        P_LOAD = 1'b1;
        P_IN   = w[1];
        tick();
        n_checks++;
        if (rdy[0] !== 1'b1) $display("FAIL full_ready_after_w1 got=%b exp=1", rdy[0]);
        else n_pass++;
        P_IN = w[2];
        tick();
        n_checks++;
        if (rdy[0] !== 1'b0) $display("FAIL full_ready_after_w2 got=%b exp=0", rdy[0]);
        else n_pass++;
        P_IN = w[3];
        tick();
        P_LOAD = 1'b0;
        n_checks++;
        if (rdy[0] !== 1'b0) $display("FAIL full_ready_after_w3 got=%b exp=0", rdy[0]);
        else n_pass++;
        for (int t = 0; t < 300 && rx_q.size() < 3; t++) tick();
        for (int t = 0; t < 40; t++) tick();
        n_checks++;
        if (rx_q.size() != 3) $display("FAIL full_frame_count got=%0d exp=3", rx_q.size());
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rx_q.size() <= i) $display("FAIL full_word%0d got=missing exp=%h", i, w[i]);
            else if (rx_q[i] !== w[i]) $display("FAIL full_word%0d got=%h exp=%h", i, rx_q[i], w[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        do_reset();
        load(32'hFFFFFFFF);
        for (int c = 1; c <= 11; c++) tick();
        n_checks++;
        if ({so[0], sb[0]} !== 2'b11) $display("FAIL midrst_pre got=%b exp=11", {so[0], sb[0]});
        else n_pass++;
        RESET = 1'b0;
        #1;
        n_checks++;
        if ({so[0], ss[0], sb[0], td[0]} !== 4'b0000)
            $display("FAIL midrst_async got=%b exp=0000", {so[0], ss[0], sb[0], td[0]});
        else n_pass++;
        tick();
        RESET = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if ({so, ss, sb, td} !== 16'h0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL midrst_quiet got=%0d active cycles exp=0", bad);
        else n_pass++;
        n_checks++;
        if (rx_q.size() != 0) $display("FAIL midrst_frames got=%0d exp=0", rx_q.size());
        else n_pass++;
    endtask

    task automatic test_loopback();
        do_reset();
        P_LOAD = 1'b1;
        P_IN   = 32'h12345678;
        tick();
        P_IN = 32'hDEADBEEF;
        tick();
        P_LOAD = 1'b0;
        P_IN   = '0;
        for (int t = 0; t < 200 && rx_q.size() < 2; t++) tick();
        n_checks++;
        if (rx_q.size() != 2) $display("FAIL loop_count got=%0d exp=2", rx_q.size());
        else n_pass++;
        n_checks++;
        if (rx_q.size() < 1 || rx_q[0] !== 32'h12345678)
            $display("FAIL loop_word0 got=%h exp=12345678", (rx_q.size() > 0) ? rx_q[0] : 32'hx);
        else n_pass++;
        n_checks++;
        if (rx_q.size() < 2 || rx_q[1] !== 32'hDEADBEEF)
            $display("FAIL loop_word1 got=%h exp=deadbeef", (rx_q.size() > 1) ? rx_q[1] : 32'hx);
        else n_pass++;
    endtask

    initial begin
        rx_cnt = 0;
        test_reset();
        test_single();
        test_lsb_first();
        test_back_to_back();
        test_full_fifo();
        test_reset_mid_frame();
        test_loopback();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/par_to_ser_tx.md
Name: par_to_ser_tx

Overview:
- Parallel-to-serial framed transmitter; the sending end of the serial link that the serial-to-parallel converter receives.
- Accepts WIDTH-bit words over a load/ready handshake into a small holding FIFO.
- Shifts each word out one bit per clock, with a one-cycle S_START frame marker on the first bit.
- Drives the converter's S_IN/S_START inputs directly and is used as its stimulus source in loopback benches.

Parameters:
- WIDTH, 32, bits per frame (≥2).
- DEPTH, 2, holding FIFO entries (power of 2, ≥1).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 first.
- GAP, 1, idle cycles forced between consecutive frames (≥0).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset asserted).
- P_IN  in  WIDTH  parallel word to send.
- P_LOAD  in  1  load request; word accepted on a rising edge where P_LOAD && P_READY.
- P_READY  out  1  FIFO not full (combinational from FIFO count).
- S_OUT  out  1  serial data, registered.
- S_START  out  1  high for exactly the cycle carrying the first bit of a frame, registered.
- S_BUSY  out  1  high while a frame's bits are on S_OUT or a GAP is running, registered.
- TX_DONE  out  1  one-cycle pulse on the cycle after the last bit of a frame, registered.

Behaviour:
- Reset (RESET=0, async): FIFO empty, state IDLE, S_OUT=0, S_START=0, S_BUSY=0, TX_DONE=0. P_READY=1 once FIFO is empty.
- FIFO: write on P_LOAD && P_READY. P_LOAD while full is ignored and the word is lost; there is no error flag. Pop only on entry to SHIFT. A write and a pop in the same cycle are both honoured, and the count is unchanged.
- State IDLE:
  - If FIFO is non-empty at an edge: pop into the shift register, go to SHIFT.
  - On that same edge, S_START=1, S_BUSY=1, and S_OUT=first bit (per MSB_FIRST).
  - Otherwise S_OUT=0.
- State SHIFT: bit counter 0..WIDTH-1, width $clog2(WIDTH).
  - Each edge presents the next bit and S_START=0.
  - When the counter reaches WIDTH-1, the last bit is held for that cycle.
  - On the next edge: S_OUT=0, TX_DONE=1, then go to GAP if GAP>0, else to IDLE.
- GAP=0 with the FIFO non-empty: the edge that leaves the last bit loads the next word directly. S_START=1 coincides with TX_DONE=1; frames are back-to-back, with no idle cycle.
- State GAP: S_OUT=0, S_BUSY=1, counts GAP cycles, then goes to IDLE. S_BUSY drops on the IDLE entry edge unless a new frame starts on that edge.
- Latency: a word loaded at edge k into an empty FIFO while IDLE has its first bit (S_START=1) visible after edge k+1. Frame length is exactly WIDTH cycles.
- P_IN is sampled only at the load edge. Later changes to P_IN do not affect queued or in-flight words.
- Reset asserted mid-frame: the frame is aborted and queued words are discarded. S_OUT=0 immediately (async); no TX_DONE is issued.
- Reset release: the block is idle on the first edge after RESET rises; nothing is transmitted until a new P_LOAD.

Test Plan:
- Single word: WIDTH=32, MSB_FIRST=1, load 32'h0000FFFF → first bit visible one edge after the load, S_START high 1 cycle, S_OUT = 16 zeros then 16 ones, TX_DONE pulse on cycle 33, S_BUSY low after GAP.
- LSB-first: MSB_FIRST=0, load 32'h0000FFFF → 16 ones then 16 zeros; load 32'h80000001 → 1, thirty 0s, 1.
- Back-to-back: GAP=0, load 32'hA5A5A5A5 and 32'h5A5A5A5A on consecutive edges → 64 contiguous data cycles, two S_START pulses exactly 32 cycles apart, second coincident with first TX_DONE. Repeat with GAP=3 → exactly 3 zero cycles between frames.
- Full FIFO: DEPTH=2, load words 1,2,3 on consecutive edges while word 0 is shifting → P_READY low after word 2, word 3 dropped, only words 0,1,2 appear on S_OUT in order.
- Reset mid-frame: drop RESET at bit 10 of 32'hFFFFFFFF → S_OUT=0 and S_START, S_BUSY, TX_DONE = 0 immediately; after release with no loads, S_OUT stays 0 for 40 cycles.
- Loopback: connect S_OUT/S_START to the serial-to-parallel converter and send 32'h12345678, 32'hDEADBEEF → converter's P_VALID pulses twice with P_OUT matching each word.
